csc_frame_ctrl: RTL and testbench
=================================

# csc_frame_ctrl

Frame-synchronous sequencer for the YUV-to-RGB colour-space conversion stage. It accepts conversion-standard updates from the register side through a valid/ready handshake, holds them pending, and drives the datapath's standard select only at frame starts, so that no frame is converted with mixed coefficients. It also tracks frame/line/pixel progress, checks frame geometry, and signals frame completion aligned to the datapath's output latency.

## Interface
- WIDTH, 1280: expected active pixels per line (href-high cycles).
- HEIGHT, 960: expected lines per frame.
- PIPE_DLY, 5: datapath latency in clocks, input vsync to output vsync.
- DEF_STD, 2'b00: conversion standard applied after reset.
- pclk  in  1  pixel clock. All logic is in one clock domain: pclk.
- rst  in  1  reset. Asynchronous and active-high.
- cfg_valid  in  1  a configuration update is offered.
- cfg_std  in  2  the requested standard. 2'b01 selects matrix A; any other value selects matrix B.
- cfg_ready  out  1  the controller can accept an update.
- in_href  in  1  line-active, from upstream.
- in_vsync  in  1  frame-active level, from upstream.
- conv_standard  out  2  standard select to the datapath.
- cfg_pending  out  1  an accepted update is waiting for a frame start.
- frame_active  out  1  the FSM is in ACTIVE.
- frame_done  out  1  one-cycle end-of-frame pulse.
- size_err  out  1  sticky geometry mismatch for the current frame.
- line_cnt  out  16  lines completed in the current frame.
- frame_cnt  out  16  frames completed, wrapping.

## Operation
- **Reset values:** conv_standard=DEF_STD, cfg_ready=1, cfg_pending=0, frame_active=0, frame_done=0, size_err=0, line_cnt=0, frame_cnt=0. FSM state is IDLE. The registered copies vsync_q and href_q are 0.
- **Edge detection:**
  - vs_rise = in_vsync & ~vsync_q; vs_fall = ~in_vsync & vsync_q.
  - hs_fall = ~in_href & href_q.
- **Config handshake:**
  - cfg_ready = ~cfg_pending.
  - A transfer occurs when cfg_valid & cfg_ready. It loads the pending register with cfg_std and sets cfg_pending.
  - When cfg_pending is set, cfg_valid is back-pressured. There is no overwrite.
- **FSM states:** IDLE, ACTIVE, DRAIN.
  - IDLE → ACTIVE on vs_rise.
    - If cfg_pending was set before this cycle, then on this cycle conv_standard takes the pending value and cfg_pending clears.
    - A transfer in the same cycle as vs_rise is not applied. It stays pending for the next frame.
    - size_err, line_cnt and the pixel counter clear.
  - ACTIVE → DRAIN on vs_fall. This loads the drain counter with PIPE_DLY-1.
  - DRAIN → IDLE when the drain counter reaches 0. frame_done pulses on that cycle, and frame_cnt increments on that cycle.
  - vs_rise while in DRAIN:
    - frame_done and the frame_cnt increment happen immediately, on that cycle.
    - The next state is ACTIVE and the counters clear.
    - The pending config is not applied, because the datapath still holds the previous frame. It remains pending.
- **Counting (ACTIVE only):**
  - The pixel counter increments on each cycle with in_href=1.
  - On hs_fall, line_cnt increments and the pixel counter clears.
  - Both counters are 16-bit and saturate at 65535.
  - href activity in IDLE or DRAIN is ignored.
- **Geometry check:**
  - On hs_fall, if the pixel count is not equal to WIDTH, set size_err.
  - On vs_fall, if line_cnt is not equal to HEIGHT, set size_err. If in_href is still 1 at vs_fall, the line is counted first, then compared.
  - size_err stays set until the next vs_rise.
- conv_standard never changes outside a vs_rise taken from IDLE.

## Timing
- All outputs are registered, except cfg_ready, which is combinational from cfg_pending.
- An accepted update becomes visible on cfg_pending one clock after the transfer.
- conv_standard changes on the clock edge at which in_vsync is first sampled high, coming from IDLE.
- frame_done is high for exactly one cycle, PIPE_DLY clocks after the edge at which in_vsync is first sampled low. This aligns with the datapath's out_vsync falling.
- frame_active follows the FSM state, registered.
- Reset asserted mid-frame returns all state to the reset values immediately. Any pending config is lost. After release, the controller waits in IDLE for a fresh vs_rise and does not resume mid-frame.

## Test plan
- **Basic frame.** WIDTH=8, HEIGHT=4, 4 lines of 8 href cycles inside vsync → line_cnt=4, size_err=0, a single frame_done 5 clocks after vsync falls, frame_cnt=1.
- **Config deferral.** Send cfg_std=2'b01 mid-frame → cfg_pending=1, cfg_ready=0, conv_standard unchanged until the next vs_rise, then conv_standard=2'b01 and cfg_pending=0.
- **Simultaneous events.**
  - cfg transfer on the vs_rise cycle → the old standard is kept for this frame and applied at the following frame start.
  - vs_rise during DRAIN → immediate frame_done, pending config still pending.
- **Geometry errors.**
  - A line of 7 pixels → size_err=1 after that line's hs_fall, cleared at the next vs_rise.
  - 3 lines in a frame → size_err=1 at vs_fall.
- **Reset mid-frame.** Assert rst in ACTIVE with a config pending → all outputs at reset values, conv_standard=DEF_STD, no frame_done. After release, href without a vsync rise leaves line_cnt=0.

Source files
------------

// File: rtl/csc_frame_ctrl.sv
// Frame-synchronous standard select, frame/line/pixel tracking and geometry check for the CSC stage.
// Outputs registered (cfg_ready combinational); frame_done lags vsync fall by PIPE_DLY; cfg held off while one update is pending.
module csc_frame_ctrl #(
    parameter int          WIDTH    = 1280,
    parameter int          HEIGHT   = 960,
    parameter int          PIPE_DLY = 5,
    parameter logic [1:0]  DEF_STD  = 2'b00
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_std,
    output logic        cfg_ready,
    input  logic        in_href,
    input  logic        in_vsync,
    output logic [1:0]  conv_standard,
    output logic        cfg_pending,
    output logic        frame_active,
    output logic        frame_done,
    output logic        size_err,
    output logic [15:0] line_cnt,
    output logic [15:0] frame_cnt
);
    localparam int          DW       = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;
    localparam logic [15:0] L_WIDTH  = 16'(WIDTH);
    localparam logic [15:0] L_HEIGHT = 16'(HEIGHT);
    localparam logic [DW-1:0] L_DRAIN = DW'(PIPE_DLY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t        r_state;
    logic          r_vsync_q, r_href_q;
    logic [1:0]    r_conv_std, r_pend_std;
    logic          r_cfg_pending, r_frame_active, r_frame_done, r_size_err;
    logic [15:0]   r_line, r_pix, r_frames;
    logic [DW-1:0] r_drain;

    logic        w_vs_rise, w_vs_fall, w_hs_fall, w_xfer;
    logic [15:0] w_pix_inc, w_line_inc, w_pix_end;

    assign w_vs_rise  = in_vsync & ~r_vsync_q;
    assign w_vs_fall  = ~in_vsync & r_vsync_q;
    assign w_hs_fall  = ~in_href & r_href_q;
    assign w_xfer     = cfg_valid & ~r_cfg_pending;
    assign w_pix_inc  = (r_pix == 16'hFFFF) ? r_pix : r_pix + 16'd1;
    assign w_line_inc = (r_line == 16'hFFFF) ? r_line : r_line + 16'd1;
    // A line still active when vsync drops ends on this cycle, including this pixel.
    assign w_pix_end  = in_href ? w_pix_inc : r_pix;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_vsync_q      <= 1'b0;
            r_href_q       <= 1'b0;
            r_conv_std     <= DEF_STD;
            r_pend_std     <= DEF_STD;
            r_cfg_pending  <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_size_err     <= 1'b0;
            r_line         <= 16'd0;
            r_pix          <= 16'd0;
            r_frames       <= 16'd0;
            r_drain        <= '0;
        end else begin
            r_vsync_q    <= in_vsync;
            r_href_q     <= in_href;
            r_frame_done <= 1'b0;
            if (w_xfer) begin
                r_pend_std    <= cfg_std;
                r_cfg_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_vs_rise) begin
                        r_state        <= S_ACTIVE;
                        r_frame_active <= 1'b1;
                        r_size_err     <= 1'b0;
                        r_line         <= 16'd0;
                        r_pix          <= 16'd0;
                        // Only an update pending before this edge applies; w_xfer cannot coincide.
                        if (r_cfg_pending) begin
                            r_conv_std    <= r_pend_std;
                            r_cfg_pending <= 1'b0;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_vs_fall) begin
                        r_state        <= S_DRAIN;
                        r_frame_active <= 1'b0;
                        r_drain        <= L_DRAIN;
                        r_pix          <= 16'd0;
                        if (w_hs_fall || in_href) begin
                            r_line <= w_line_inc;
                            if (w_pix_end != L_WIDTH || w_line_inc != L_HEIGHT)
                                r_size_err <= 1'b1;
                        end else if (r_line != L_HEIGHT) begin
                            r_size_err <= 1'b1;
                        end
                    end else if (w_hs_fall) begin
                        r_line <= w_line_inc;
                        r_pix  <= 16'd0;
                        if (r_pix != L_WIDTH)
                            r_size_err <= 1'b1;
                    end else if (in_href) begin
                        r_pix <= w_pix_inc;
                    end
                end
                S_DRAIN: begin
                    // Early frame start: close the old frame now, but keep the pending standard.
                    if (w_vs_rise) begin
                        r_frame_done   <= 1'b1;
                        r_frames       <= r_frames + 16'd1;
                        r_state        <= S_ACTIVE;
                        r_frame_active <= 1'b1;
                        r_size_err     <= 1'b0;
                        r_line         <= 16'd0;
                        r_pix          <= 16'd0;
                    end else if (r_drain == '0) begin
                        r_frame_done <= 1'b1;
                        r_frames     <= r_frames + 16'd1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready     = ~r_cfg_pending;
    assign conv_standard = r_conv_std;
    assign cfg_pending   = r_cfg_pending;
    assign frame_active  = r_frame_active;
    assign frame_done    = r_frame_done;
    assign size_err      = r_size_err;
    assign line_cnt      = r_line;
    assign frame_cnt     = r_frames;
endmodule

// File: tb/tb_csc_frame_ctrl.sv
// Bench for csc_frame_ctrl: directed frame scenarios plus randomized frames against a frame-level model.
module tb_csc_frame_ctrl;
    localparam int         W   = 8;
    localparam int         H   = 4;
    localparam int         PD  = 5;
    localparam logic [1:0] DEF = 2'b11;

    logic        pclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [1:0]  cfg_std;
    logic        cfg_ready;
    logic        in_href;
    logic        in_vsync;
    logic [1:0]  conv_standard;
    logic        cfg_pending;
    logic        frame_active;
    logic        frame_done;
    logic        size_err;
    logic [15:0] line_cnt;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model state
    logic [1:0]  m_std;
    logic [1:0]  m_pstd;
    bit          m_pend;
    bit          m_in_drain;
    bit          m_err;
    logic [15:0] m_frames;

    csc_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .PIPE_DLY(PD), .DEF_STD(DEF)) dut (
        .pclk(pclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_std(cfg_std), .cfg_ready(cfg_ready),
        .in_href(in_href), .in_vsync(in_vsync), .conv_standard(conv_standard),
        .cfg_pending(cfg_pending), .frame_active(frame_active), .frame_done(frame_done),
        .size_err(size_err), .line_cnt(line_cnt), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic model_reset;
        m_std = DEF; m_pstd = DEF; m_pend = 0; m_in_drain = 0; m_err = 0; m_frames = 16'd0;
    endtask

    // One frame: vs_rise, nlines lines (line bad_line has bad_w pixels), optional cfg offers, vs_fall, drain_wait ticks.
    task automatic run_frame(input string tag, input int nlines, input int bad_line, input int bad_w,
                             input int cfg_line, input logic [1:0] cfg_val, input bit cfg_at_rise,
                             input int drain_wait);
        bit pb;
        bit exp_done;
        int w;
        in_vsync = 1'b1;
        if (cfg_at_rise) begin cfg_valid = 1'b1; cfg_std = cfg_val; end
        tick();
        cfg_valid = 1'b0;
        pb = m_pend;
        exp_done = m_in_drain;
        if (m_in_drain) m_frames = m_frames + 16'd1;
        else if (pb) begin m_std = m_pstd; m_pend = 0; end
        if (cfg_at_rise && !pb) begin m_pend = 1; m_pstd = cfg_val; end
        m_in_drain = 0;
        m_err = 0;
        n_tests++;
        if (conv_standard !== m_std) begin n_fail++; $display("FAIL %s start conv_standard got %0d want %0d", tag, conv_standard, m_std); end
        n_tests++;
        if (cfg_pending !== m_pend) begin n_fail++; $display("FAIL %s start cfg_pending got %0d want %0d", tag, cfg_pending, m_pend); end
        n_tests++;
        if (frame_done !== exp_done || frame_cnt !== m_frames) begin
            n_fail++; $display("FAIL %s start frame_done/frame_cnt got %0d/%0d want %0d/%0d", tag, frame_done, frame_cnt, exp_done, m_frames);
        end
        n_tests++;
        if (frame_active !== 1'b1 || line_cnt !== 16'd0 || size_err !== 1'b0) begin
            n_fail++; $display("FAIL %s start active/line/err got %0d/%0d/%0d want 1/0/0", tag, frame_active, line_cnt, size_err);
        end
        for (int i = 0; i < nlines; i++) begin
            w = (i == bad_line) ? bad_w : W;
            in_href = 1'b1;
            repeat (w) tick();
            in_href = 1'b0;
            tick();
            if (w != W) m_err = 1;
            n_tests++;
            if (line_cnt !== 16'(i + 1) || size_err !== m_err || frame_done !== 1'b0) begin
                n_fail++; $display("FAIL %s line%0d line/err/done got %0d/%0d/%0d want %0d/%0d/0", tag, i, line_cnt, size_err, frame_done, i + 1, m_err);
            end
            if (i == cfg_line) begin
                cfg_valid = 1'b1; cfg_std = cfg_val;
                tick();
                cfg_valid = 1'b0;
                if (!m_pend) begin m_pend = 1; m_pstd = cfg_val; end
                n_tests++;
                if (cfg_pending !== m_pend || cfg_ready !== !m_pend || conv_standard !== m_std) begin
                    n_fail++; $display("FAIL %s cfg pend/rdy/std got %0d/%0d/%0d want %0d/%0d/%0d", tag, cfg_pending, cfg_ready, conv_standard, m_pend, !m_pend, m_std);
                end
            end else begin
                tick();
            end
        end
        in_vsync = 1'b0;
        tick();
        if (nlines != H) m_err = 1;
        n_tests++;
        if (size_err !== m_err || line_cnt !== 16'(nlines) || frame_active !== 1'b0) begin
            n_fail++; $display("FAIL %s vs_fall err/line/active got %0d/%0d/%0d want %0d/%0d/0", tag, size_err, line_cnt, frame_active, m_err, nlines);
        end
        for (int k = 1; k <= drain_wait; k++) begin
            tick();
            if (k == PD) m_frames = m_frames + 16'd1;
            n_tests++;
            if (frame_done !== (k == PD)) begin
                n_fail++; $display("FAIL %s drain k=%0d frame_done got %0d want %0d", tag, k, frame_done, (k == PD));
            end
        end
        if (drain_wait >= PD) begin
            n_tests++;
            if (frame_cnt !== m_frames || conv_standard !== m_std) begin
                n_fail++; $display("FAIL %s end frame_cnt/std got %0d/%0d want %0d/%0d", tag, frame_cnt, conv_standard, m_frames, m_std);
            end
        end
        m_in_drain = (drain_wait < PD);
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_valid = 1'b0; cfg_std = 2'b00; in_href = 1'b0; in_vsync = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        model_reset();
        n_tests++;
        if (conv_standard !== DEF || cfg_ready !== 1'b1 || cfg_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset std/rdy/pend got %0d/%0d/%0d want %0d/1/0", conv_standard, cfg_ready, cfg_pending, DEF);
        end
        n_tests++;
        if (frame_active !== 1'b0 || frame_done !== 1'b0 || size_err !== 1'b0 || line_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset act/done/err/line/frm got %0d/%0d/%0d/%0d/%0d want zeros", frame_active, frame_done, size_err, line_cnt, frame_cnt);
        end
    endtask

    task automatic test_basic;
        run_frame("basic", H, -1, W, -1, 2'b00, 1'b0, PD);
    endtask

    task automatic test_cfg_defer;
        run_frame("defer_a", H, -1, W, 1, 2'b01, 1'b0, PD);
        run_frame("defer_b", H, -1, W, -1, 2'b00, 1'b0, PD + 2);
    endtask

    task automatic test_simultaneous;
        run_frame("simul_rise", H, -1, W, -1, 2'b10, 1'b1, PD);
        run_frame("simul_applied", H, -1, W, 2, 2'b01, 1'b0, 2);
        run_frame("simul_drain", H, -1, W, -1, 2'b00, 1'b0, PD - 1);
        run_frame("simul_drain2", H, -1, W, -1, 2'b00, 1'b0, PD);
        run_frame("simul_late", H, -1, W, -1, 2'b00, 1'b0, PD);
    endtask

    task automatic test_geometry;
        run_frame("geom_short_line", H, 1, W - 1, -1, 2'b00, 1'b0, PD);
        run_frame("geom_clean", H, -1, W, -1, 2'b00, 1'b0, PD);
        run_frame("geom_3lines", H - 1, -1, W, -1, 2'b00, 1'b0, PD);
        run_frame("geom_long_line", H, 3, W + 1, -1, 2'b00, 1'b0, PD);
    endtask

    task automatic test_random;
        int nl, bl, bw, cl, dw;
        for (int f = 0; f < 24; f++) begin
            nl = $urandom_range(H + 1, H - 1);
            bl = ($urandom_range(2, 0) == 0) ? int'($urandom_range(nl - 1, 0)) : -1;
            bw = $urandom_range(W + 2, W - 2);
            cl = ($urandom_range(1, 0) == 0) ? int'($urandom_range(nl - 1, 0)) : -1;
            dw = $urandom_range(PD + 1, 0);
            if (f == 23) dw = PD;
            run_frame("random", nl, bl, bw, cl, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), dw);
        end
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        seen_done = 0;
        run_frame("pre_reset", H, -1, W, -1, 2'b00, 1'b0, PD);
        in_vsync = 1'b1;
        tick();
        in_href = 1'b1;
        repeat (W) tick();
        in_href = 1'b0;
        cfg_valid = 1'b1; cfg_std = 2'b01;
        tick();
        cfg_valid = 1'b0;
        n_tests++;
        if (cfg_pending !== 1'b1 || frame_active !== 1'b1) begin
            n_fail++; $display("FAIL rstmid setup pend/active got %0d/%0d want 1/1", cfg_pending, frame_active);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (conv_standard !== DEF || cfg_pending !== 1'b0 || cfg_ready !== 1'b1 || frame_active !== 1'b0 ||
            line_cnt !== 16'd0 || frame_cnt !== 16'd0 || size_err !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid async std/pend/rdy/act/line/frm got %0d/%0d/%0d/%0d/%0d/%0d want %0d/0/1/0/0/0",
                               conv_standard, cfg_pending, cfg_ready, frame_active, line_cnt, frame_cnt, DEF);
        end
        in_vsync = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            in_href = 1'b1;
            repeat (W) begin tick(); if (frame_done) seen_done = 1; end
            in_href = 1'b0;
            tick(); if (frame_done) seen_done = 1;
        end
        n_tests++;
        if (line_cnt !== 16'd0 || frame_active !== 1'b0 || seen_done !== 1'b0 || conv_standard !== DEF) begin
            n_fail++; $display("FAIL rstmid after line/act/done/std got %0d/%0d/%0d/%0d want 0/0/0/%0d", line_cnt, frame_active, seen_done, conv_standard, DEF);
        end
        run_frame("post_reset", H, -1, W, 0, 2'b01, 1'b0, PD);
        run_frame("post_reset2", H, -1, W, -1, 2'b00, 1'b0, PD);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cfg_defer();
        test_simultaneous();
        test_geometry();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
